ls_queue_param: RTL and testbench
=================================

LS_QUEUE_PARAM -- requirements
Module: ls_queue_param

Interface
REQ-001 Parameter DEPTH, default 16, number of queue entries; power of two, at least 4.
REQ-002 Parameter TAG_W, default 4, ROB tag width; tag 0 means "no dependency / value ready".
REQ-003 Parameter CDB_N, default 2, number of CDB broadcast channels.
REQ-004 Parameter AFULL_SLACK, default 2, free-slot margin below which the upstream ready output drops.
REQ-005 Ports, one per line, clock and reset first:
  clk_in  in  1  single clock; all logic on rising edge
  rst_in  in  1  synchronous, active-high reset
  rdy_in  in  1  global enable; low = hold state
  lbuffer_rdy_in  in  1  load buffer can accept a load
  instqueue_rdy_out  out  1  upstream may dispatch
  count_out  out  clog2(DEPTH)+1  current occupancy
  dispatcher_en_in  in  1  dispatch valid
  dispatcher_vj_in / dispatcher_vk_in  in  32  base / store-data operand values
  dispatcher_qj_in / dispatcher_qk_in  in  TAG_W  operand producer tags
  dispatcher_inst_type_in  in  `INST_TYPE_WIDTH  opcode class (`LB..`LHU, `SB..`SW)
  dispatcher_A_in  in  32  immediate offset
  dispatcher_dest_in  in  TAG_W  ROB entry of this instruction
  cdb_en_in  in  CDB_N  per-channel broadcast valid
  cdb_dest_in  in  CDB_N*TAG_W  packed tags; channel k at [k*TAG_W +: TAG_W]
  cdb_value_in  in  CDB_N*32  packed values; channel k at [k*32 +: 32]
  rob_flush_in  in  1  mispredict flush
  rob_en_out, rob_dest_out, rob_value_out  out  1, TAG_W, 32  store data to ROB
  addressUnit_en_out  out  1  issue valid
  addressUnit_A_out, addressUnit_vj_out  out  32, 32  offset, base
  addressUnit_dest_out  out  TAG_W  ROB tag
  addressUnit_inst_type_out  out  `INST_TYPE_WIDTH  opcode class

Function
REQ-006 Circular FIFO with head, tail (clog2(DEPTH) bits, natural wrap) and separate occupancy counter; all DEPTH slots usable.
REQ-007 Empty = count 0; full = count DEPTH; count_out equals count.
REQ-008 instqueue_rdy_out = (DEPTH - count) > AFULL_SLACK, combinational from registered count.
REQ-009 Dispatch when not full: write entry at tail, tail+1; dispatch while full is dropped, state unchanged.
REQ-010 Dispatch bypass: if dispatcher_qj_in (or qk) is nonzero and matches any valid CDB channel the same cycle, store that channel's value and tag 0.
REQ-011 Wakeup: every busy entry with nonzero qj (qk) matching a valid CDB channel captures value, clears tag; on duplicate match the highest channel index wins.
REQ-012 Issue from head only, in order, at most one per cycle.
REQ-013 Load (`LB..`LHU) issues when lbuffer_rdy_in and qj==0: addressUnit_en_out pulses one cycle with A, vj, dest, type; head+1.
REQ-014 Store (`SB..`SW) issues when qj==0 and qk==0, independent of lbuffer_rdy_in: addressUnit pulse as REQ-013 plus rob_en_out pulse with rob_dest_out=dest, rob_value_out = vk zero-extended from bits 7:0 (SB), 15:0 (SH), 31:0 (SW).
REQ-015 Head operands are evaluated from registered state; a CDB match on the head this cycle allows issue next cycle (1-cycle wakeup-to-issue).
REQ-016 Dispatch and issue in the same cycle: count unchanged; dispatch into empty queue issues no earlier than next cycle.
REQ-017 All *_en_out outputs are single-cycle pulses, low in any cycle without issue; data outputs hold last value.
REQ-018 rob_flush_in (with rdy_in) clears all entries, head=tail=count=0, outputs low next cycle; flush overrides same-cycle dispatch, issue and wakeup.
REQ-019 rdy_in low: no state change, *_en_out low.

Reset
REQ-020 rst_in high at a clock edge, regardless of rdy_in: head, tail, count 0, all busy bits 0, rob_en_out and addressUnit_en_out 0; data outputs 0.
REQ-021 Reset mid-operation discards all entries; instqueue_rdy_out high the following cycle.

Verification
REQ-022 Fill: DEPTH=16, 14 dispatches of ready LW, lbuffer_rdy_in=0 -> count_out=14, instqueue_rdy_out low; 15th and 16th accepted, 17th dropped, count_out=16.
REQ-023 Store: SB, qj=0, vj=0x1000, A=4, qk=3; CDB ch1 tag3 value 0x12345678 -> next cycle rob_en_out=1, rob_value_out=0x00000078, addressUnit_A_out=4, vj=0x1000.
REQ-024 Bypass: dispatch LW qj=5 while cdb ch0 tag5 value 0xABCD valid -> entry issues next cycle with vj=0xABCD.
REQ-025 Order: head LW qj=2 pending, younger ready SW behind -> no issue until tag2 broadcast; LW issues, then SW one cycle later.
REQ-026 Wrap: 40 dispatch/issue pairs through DEPTH=4 -> in-order dest tags, count_out never >4.
REQ-027 Flush with 5 entries and same-cycle dispatch -> next cycle count_out=0, no en pulses, instqueue_rdy_out=1.

Source files
------------

// File: rtl/ls_queue_param.sv
// rtl/ls_queue_param.sv - in-order load/store queue with CDB wakeup and head-only issue
`ifndef INST_TYPE_WIDTH
`define INST_TYPE_WIDTH 6
`define LB  6'd10
`define LH  6'd11
`define LW  6'd12
`define LBU 6'd13
`define LHU 6'd14
`define SB  6'd15
`define SH  6'd16
`define SW  6'd17
`endif

module ls_queue_param #(
  parameter int DEPTH       = 16,
  parameter int TAG_W       = 4,
  parameter int CDB_N       = 2,
  parameter int AFULL_SLACK = 2
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic                        lbuffer_rdy_in,
  output logic                        instqueue_rdy_out,
  output logic [$clog2(DEPTH):0]      count_out,
  input  logic                        dispatcher_en_in,
  input  logic [31:0]                 dispatcher_vj_in,
  input  logic [31:0]                 dispatcher_vk_in,
  input  logic [TAG_W-1:0]            dispatcher_qj_in,
  input  logic [TAG_W-1:0]            dispatcher_qk_in,
  input  logic [`INST_TYPE_WIDTH-1:0] dispatcher_inst_type_in,
  input  logic [31:0]                 dispatcher_A_in,
  input  logic [TAG_W-1:0]            dispatcher_dest_in,
  input  logic [CDB_N-1:0]            cdb_en_in,
  input  logic [CDB_N*TAG_W-1:0]      cdb_dest_in,
  input  logic [CDB_N*32-1:0]         cdb_value_in,
  input  logic                        rob_flush_in,
  output logic                        rob_en_out,
  output logic [TAG_W-1:0]            rob_dest_out,
  output logic [31:0]                 rob_value_out,
  output logic                        addressUnit_en_out,
  output logic [31:0]                 addressUnit_A_out,
  output logic [31:0]                 addressUnit_vj_out,
  output logic [TAG_W-1:0]            addressUnit_dest_out,
  output logic [`INST_TYPE_WIDTH-1:0] addressUnit_inst_type_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Returns {hit, value}; later channels overwrite earlier ones so the highest index wins.
  function automatic logic [32:0] cdb_match(
    input logic [TAG_W-1:0]       tag,
    input logic [CDB_N-1:0]       en,
    input logic [CDB_N*TAG_W-1:0] dest,
    input logic [CDB_N*32-1:0]    val
  );
    logic [32:0] m;
    m = '0;
    if (tag != '0) begin
      for (int k = 0; k < CDB_N; k++) begin
        if (en[k] && (dest[k*TAG_W +: TAG_W] == tag)) m = {1'b1, val[k*32 +: 32]};
      end
    end
    return m;
  endfunction

  logic [DEPTH-1:0]            r_busy;
  logic [`INST_TYPE_WIDTH-1:0] r_type [DEPTH];
  logic [31:0]                 r_vj   [DEPTH];
  logic [31:0]                 r_vk   [DEPTH];
  logic [31:0]                 r_A    [DEPTH];
  logic [TAG_W-1:0]            r_qj   [DEPTH];
  logic [TAG_W-1:0]            r_qk   [DEPTH];
  logic [TAG_W-1:0]            r_dest [DEPTH];
  logic [PW-1:0]               r_head;
  logic [PW-1:0]               r_tail;
  logic [CW-1:0]               r_count;

  logic [32:0]                 w_wj [DEPTH];
  logic [32:0]                 w_wk [DEPTH];
  logic [32:0]                 w_dj;
  logic [32:0]                 w_dk;
  logic [`INST_TYPE_WIDTH-1:0] w_h_type;
  logic                        w_h_store;
  logic                        w_empty;
  logic                        w_full;
  logic                        w_issue;
  logic                        w_disp;
  logic [31:0]                 w_st_val;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_wj[i] = cdb_match(r_qj[i], cdb_en_in, cdb_dest_in, cdb_value_in);
      w_wk[i] = cdb_match(r_qk[i], cdb_en_in, cdb_dest_in, cdb_value_in);
    end
    w_dj = cdb_match(dispatcher_qj_in, cdb_en_in, cdb_dest_in, cdb_value_in);
    w_dk = cdb_match(dispatcher_qk_in, cdb_en_in, cdb_dest_in, cdb_value_in);
  end

  // Issue looks only at registered head state, so a same-cycle broadcast issues one cycle later.
  assign w_h_type  = r_type[r_head];
  assign w_h_store = (w_h_type >= `SB) && (w_h_type <= `SW);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_issue   = rdy_in && !rob_flush_in && !w_empty && (r_qj[r_head] == '0) &&
                     (w_h_store ? (r_qk[r_head] == '0) : lbuffer_rdy_in);
  assign w_disp    = rdy_in && !rob_flush_in && dispatcher_en_in && !w_full;

  always_comb begin
    w_st_val = r_vk[r_head];
    if (w_h_type == `SB)      w_st_val = {24'd0, r_vk[r_head][7:0]};
    else if (w_h_type == `SH) w_st_val = {16'd0, r_vk[r_head][15:0]};
  end

  assign count_out         = r_count;
  assign instqueue_rdy_out = (DEPTH - int'(r_count)) > AFULL_SLACK;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_busy  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy_in) begin
      if (rob_flush_in) begin
        r_busy  <= '0;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_busy[i] && w_wj[i][32]) begin
            r_vj[i] <= w_wj[i][31:0];
            r_qj[i] <= '0;
          end
          if (r_busy[i] && w_wk[i][32]) begin
            r_vk[i] <= w_wk[i][31:0];
            r_qk[i] <= '0;
          end
        end
        // The tail slot is never busy while not full, so it cannot collide with wakeup writes.
        if (w_disp) begin
          r_busy[r_tail] <= 1'b1;
          r_type[r_tail] <= dispatcher_inst_type_in;
          r_A[r_tail]    <= dispatcher_A_in;
          r_dest[r_tail] <= dispatcher_dest_in;
          r_vj[r_tail]   <= w_dj[32] ? w_dj[31:0] : dispatcher_vj_in;
          r_qj[r_tail]   <= w_dj[32] ? '0 : dispatcher_qj_in;
          r_vk[r_tail]   <= w_dk[32] ? w_dk[31:0] : dispatcher_vk_in;
          r_qk[r_tail]   <= w_dk[32] ? '0 : dispatcher_qk_in;
          r_tail         <= r_tail + PW'(1);
        end
        if (w_issue) begin
          r_busy[r_head] <= 1'b0;
          r_head         <= r_head + PW'(1);
        end
        r_count <= r_count + CW'(w_disp) - CW'(w_issue);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      addressUnit_en_out        <= 1'b0;
      addressUnit_A_out         <= '0;
      addressUnit_vj_out        <= '0;
      addressUnit_dest_out      <= '0;
      addressUnit_inst_type_out <= '0;
      rob_en_out                <= 1'b0;
      rob_dest_out              <= '0;
      rob_value_out             <= '0;
    end else begin
      addressUnit_en_out <= w_issue;
      rob_en_out         <= w_issue && w_h_store;
      if (w_issue) begin
        addressUnit_A_out         <= r_A[r_head];
        addressUnit_vj_out        <= r_vj[r_head];
        addressUnit_dest_out      <= r_dest[r_head];
        addressUnit_inst_type_out <= w_h_type;
        if (w_h_store) begin
          rob_dest_out  <= r_dest[r_head];
          rob_value_out <= w_st_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_ls_queue_param.sv
// tb/tb_ls_queue_param.sv - directed self-checking bench for ls_queue_param
`ifndef INST_TYPE_WIDTH
`define INST_TYPE_WIDTH 6
`define LB  6'd10
`define LH  6'd11
`define LW  6'd12
`define LBU 6'd13
`define LHU 6'd14
`define SB  6'd15
`define SH  6'd16
`define SW  6'd17
`endif

module tb_ls_queue_param;
  logic        clk = 1'b0;
  logic        rst, rdy, lbuf, en, flush;
  logic [31:0] vj, vk, A;
  logic [3:0]  qj, qk, dest;
  logic [5:0]  ty;
  logic [1:0]  cdb_en;
  logic [7:0]  cdb_dest;
  logic [63:0] cdb_value;

  logic        q_rdy, rob_en, au_en;
  logic [4:0]  cnt;
  logic [3:0]  rob_dest, au_dest;
  logic [31:0] rob_value, au_A, au_vj;
  logic [5:0]  au_type;

  logic        q_rdy4, rob_en4, au_en4;
  logic [2:0]  cnt4;
  logic [3:0]  rob_dest4, au_dest4;
  logic [31:0] rob_value4, au_A4, au_vj4;
  logic [5:0]  au_type4;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ls_queue_param #(.DEPTH(16)) dut16 (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .lbuffer_rdy_in(lbuf),
    .instqueue_rdy_out(q_rdy), .count_out(cnt),
    .dispatcher_en_in(en), .dispatcher_vj_in(vj), .dispatcher_vk_in(vk),
    .dispatcher_qj_in(qj), .dispatcher_qk_in(qk), .dispatcher_inst_type_in(ty),
    .dispatcher_A_in(A), .dispatcher_dest_in(dest),
    .cdb_en_in(cdb_en), .cdb_dest_in(cdb_dest), .cdb_value_in(cdb_value),
    .rob_flush_in(flush),
    .rob_en_out(rob_en), .rob_dest_out(rob_dest), .rob_value_out(rob_value),
    .addressUnit_en_out(au_en), .addressUnit_A_out(au_A), .addressUnit_vj_out(au_vj),
    .addressUnit_dest_out(au_dest), .addressUnit_inst_type_out(au_type)
  );

  ls_queue_param #(.DEPTH(4)) dut4 (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .lbuffer_rdy_in(lbuf),
    .instqueue_rdy_out(q_rdy4), .count_out(cnt4),
    .dispatcher_en_in(en), .dispatcher_vj_in(vj), .dispatcher_vk_in(vk),
    .dispatcher_qj_in(qj), .dispatcher_qk_in(qk), .dispatcher_inst_type_in(ty),
    .dispatcher_A_in(A), .dispatcher_dest_in(dest),
    .cdb_en_in(cdb_en), .cdb_dest_in(cdb_dest), .cdb_value_in(cdb_value),
    .rob_flush_in(flush),
    .rob_en_out(rob_en4), .rob_dest_out(rob_dest4), .rob_value_out(rob_value4),
    .addressUnit_en_out(au_en4), .addressUnit_A_out(au_A4), .addressUnit_vj_out(au_vj4),
    .addressUnit_dest_out(au_dest4), .addressUnit_inst_type_out(au_type4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; en = 1'b0; flush = 1'b0; cdb_en = 2'b00;
    cdb_dest = 8'h00; cdb_value = 64'h0;
    qj = 4'd0; qk = 4'd0; vj = 32'h0; vk = 32'h0; A = 32'h0; dest = 4'd0; ty = `LW;
  endtask

  task automatic disp(input logic [5:0] t, input logic [3:0] j, input logic [3:0] k,
                      input logic [31:0] v_j, input logic [31:0] v_k,
                      input logic [31:0] a, input logic [3:0] d);
    en = 1'b1; ty = t; qj = j; qk = k; vj = v_j; vk = v_k; A = a; dest = d;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [3:0] d_exp;

  initial begin
    rdy = 1'b1; lbuf = 1'b0;
    do_reset();
    chk("rst_count", cnt, 0);
    chk("rst_qrdy", q_rdy, 1);
    chk("rst_au_en", au_en, 0);
    chk("rst_rob_en", rob_en, 0);
    chk("rst_au_A", au_A, 0);
    chk("rst_rob_val", rob_value, 0);

    // fill to full with load buffer blocked
    lbuf = 1'b0;
    for (int i = 0; i < 17; i++) begin
      disp(`LW, 4'd0, 4'd0, 32'h100 + i, 32'h0, 32'h0, 4'(i + 1));
      tick();
      if (i == 12) begin
        chk("fill13_cnt", cnt, 13);
        chk("fill13_qrdy", q_rdy, 1);
      end
      if (i == 13) begin
        chk("fill14_cnt", cnt, 14);
        chk("fill14_qrdy", q_rdy, 0);
      end
    end
    chk("full_cnt", cnt, 16);
    chk("full_no_issue", au_en, 0);
    idle(); lbuf = 1'b1;
    tick();
    chk("drain1_en", au_en, 1);
    chk("drain1_dest", au_dest, 1);
    chk("drain1_vj", au_vj, 32'h100);
    chk("drain1_cnt", cnt, 15);
    tick();
    chk("drain2_dest", au_dest, 2);
    chk("drain2_cnt", cnt, 14);

    // SB waits on qk, woken by CDB channel 1
    do_reset();
    disp(`SB, 4'd0, 4'd3, 32'h1000, 32'h0, 32'd4, 4'd7);
    tick();
    idle(); cdb_en = 2'b10; cdb_dest = {4'd3, 4'd9}; cdb_value = {32'h12345678, 32'h0};
    tick();
    chk("sb_wait_rob_en", rob_en, 0);
    idle();
    tick();
    chk("sb_rob_en", rob_en, 1);
    chk("sb_au_en", au_en, 1);
    chk("sb_rob_val", rob_value, 32'h00000078);
    chk("sb_rob_dest", rob_dest, 7);
    chk("sb_au_A", au_A, 4);
    chk("sb_au_vj", au_vj, 32'h1000);
    tick();
    chk("sb_pulse_end", rob_en, 0);

    // SH with both channels matching: channel 1 must win
    disp(`SH, 4'd0, 4'd4, 32'h0, 32'h0, 32'h0, 4'd9);
    tick();
    idle(); cdb_en = 2'b11; cdb_dest = {4'd4, 4'd4}; cdb_value = {32'hCAFEBEEF, 32'h11112222};
    tick();
    idle();
    tick();
    chk("sh_dup_val", rob_value, 32'h0000BEEF);
    chk("sh_dup_dest", rob_dest, 9);

    // dispatch bypass from CDB channel 0
    do_reset(); lbuf = 1'b1;
    disp(`LW, 4'd5, 4'd0, 32'h0, 32'h0, 32'h0, 4'd3);
    cdb_en = 2'b01; cdb_dest = {4'd0, 4'd5}; cdb_value = {32'h0, 32'h0000ABCD};
    tick();
    chk("byp_no_same_cycle", au_en, 0);
    idle();
    tick();
    chk("byp_en", au_en, 1);
    chk("byp_vj", au_vj, 32'h0000ABCD);
    chk("byp_dest", au_dest, 3);

    // in-order: blocked LW holds back a ready SW
    do_reset(); lbuf = 1'b1;
    disp(`LW, 4'd2, 4'd0, 32'h0, 32'h0, 32'd8, 4'd1);
    tick();
    disp(`SW, 4'd0, 4'd0, 32'h0, 32'h55, 32'h0, 4'd2);
    tick();
    idle();
    tick();
    chk("ord_hold1", au_en, 0);
    tick();
    chk("ord_hold2", au_en, 0);
    cdb_en = 2'b01; cdb_dest = {4'd0, 4'd2}; cdb_value = {32'h0, 32'h200};
    tick();
    chk("ord_hold3", au_en, 0);
    idle();
    tick();
    chk("ord_ld_en", au_en, 1);
    chk("ord_ld_dest", au_dest, 1);
    chk("ord_ld_vj", au_vj, 32'h200);
    chk("ord_ld_rob", rob_en, 0);
    tick();
    chk("ord_st_dest", au_dest, 2);
    chk("ord_st_rob", rob_en, 1);
    chk("ord_st_val", rob_value, 32'h55);
    tick();
    chk("ord_done_en", au_en, 0);
    chk("ord_done_cnt", cnt, 0);

    // global enable low holds everything
    do_reset(); lbuf = 1'b1; rdy = 1'b0;
    disp(`LW, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0, 4'd4);
    tick();
    chk("rdy0_no_disp", cnt, 0);
    rdy = 1'b1;
    tick();
    chk("rdy1_disp", cnt, 1);
    idle(); rdy = 1'b0;
    tick();
    chk("rdy0_no_issue", au_en, 0);
    chk("rdy0_cnt", cnt, 1);
    rdy = 1'b1;
    tick();
    chk("rdy1_issue", au_en, 1);
    chk("rdy1_dest", au_dest, 4);

    // reset mid-operation with rdy_in low
    do_reset(); lbuf = 1'b0;
    for (int i = 0; i < 15; i++) begin
      disp(`LW, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0, 4'd1);
      tick();
    end
    chk("mid_qrdy_low", q_rdy, 0);
    idle(); rst = 1'b1; rdy = 1'b0;
    tick();
    rst = 1'b0; rdy = 1'b1;
    chk("mid_rst_cnt", cnt, 0);
    chk("mid_rst_qrdy", q_rdy, 1);

    // flush with 5 entries and a same-cycle dispatch
    do_reset(); lbuf = 1'b0;
    for (int i = 0; i < 5; i++) begin
      disp(`LW, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0, 4'(i + 1));
      tick();
    end
    chk("fl_pre_cnt", cnt, 5);
    disp(`SW, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0, 4'd8);
    flush = 1'b1; lbuf = 1'b1;
    tick();
    chk("fl_cnt", cnt, 0);
    chk("fl_au_en", au_en, 0);
    chk("fl_rob_en", rob_en, 0);
    chk("fl_qrdy", q_rdy, 1);
    idle();
    tick();
    chk("fl_after_en", au_en, 0);
    chk("fl_after_cnt", cnt, 0);

    // 40 dispatch/issue pairs through the DEPTH=4 instance
    do_reset(); lbuf = 1'b1;
    for (int i = 0; i <= 40; i++) begin
      if (i < 40) disp(`LW, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0, 4'((i % 15) + 1));
      else idle();
      tick();
      chk("wrap_cnt_le4", cnt4 <= 3'd4, 1);
      if (i >= 1) begin
        d_exp = 4'(((i - 1) % 15) + 1);
        chk("wrap_en", au_en4, 1);
        chk("wrap_dest", au_dest4, d_exp);
      end
    end
    chk("wrap_end_cnt", cnt4, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
